// File: rtl/mem_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with single-word lines.
// Hits complete combinationally in the request cycle; misses optionally write back
// a dirty victim, fill from backing memory, and complete in a one-cycle FINISH state.
module mem_cache_ctrl #(
  parameter int IDX_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready
);
  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 15 - IDX_W;

  typedef enum logic [1:0] {IDLE, WB, FILL, FINISH} state_t;

  state_t                        state_q, state_d;
  logic [15:0]                   addr_q, addr_d;
  logic [15:0]                   wdat_q, wdat_d;
  logic                          opwr_q, opwr_d;
  logic [LINES-1:0]              valid_q, dirty_q;
  logic [LINES-1:0][TAG_W-1:0]   tag_q;
  logic [LINES-1:0][15:0]        line_q;

  // single line write port, driven by the FSM
  logic                          we;
  logic [IDX_W-1:0]              widx;
  logic [TAG_W-1:0]              wtag;
  logic [15:0]                   wdata;
  logic                          wdirty;

  logic [IDX_W-1:0]              req_idx, l_idx;
  logic [TAG_W-1:0]              req_tag, l_tag;
  logic                          illegal, legal, hit;

  assign req_idx = Addr[IDX_W:1];
  assign req_tag = Addr[15:IDX_W+1];
  assign l_idx   = addr_q[IDX_W:1];
  assign l_tag   = addr_q[15:IDX_W+1];
  assign illegal = (Rd & Wr) | ((Rd | Wr) & Addr[0]);
  assign legal   = (Rd | Wr) & ~illegal;
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // next-state, line-write and output decode; everything is forced low while reset is held
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    opwr_d    = opwr_q;
    we        = 1'b0;
    widx      = l_idx;
    wtag      = l_tag;
    wdata     = 16'h0000;
    wdirty    = 1'b0;
    DataOut   = 16'h0000;
    Done      = 1'b0;
    Stall     = 1'b0;
    CacheHit  = 1'b0;
    err       = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    if (rst) begin
      unique case (state_q)
        IDLE: begin
          if (illegal) begin
            err = 1'b1;
          end else if (legal) begin
            if (hit) begin
              Done     = 1'b1;
              CacheHit = 1'b1;
              if (Rd) begin
                DataOut = line_q[req_idx];
              end else begin
                we     = 1'b1;
                widx   = req_idx;
                wtag   = req_tag;
                wdata  = DataIn;
                wdirty = 1'b1;
              end
            end else begin
              Stall   = 1'b1;
              addr_d  = Addr;
              wdat_d  = DataIn;
              opwr_d  = Wr;
              state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WB : FILL;
            end
          end
        end
        WB: begin
          Stall     = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = {tag_q[l_idx], l_idx, 1'b0};
          mem_wdata = line_q[l_idx];
          if (mem_ready) state_d = FILL;
        end
        FILL: begin
          Stall    = 1'b1;
          mem_rd   = 1'b1;
          mem_addr = addr_q;
          if (mem_ready) begin
            we      = 1'b1;
            wdata   = mem_rdata;
            wdirty  = 1'b0;
            state_d = FINISH;
          end
        end
        FINISH: begin
          Done = 1'b1;
          if (opwr_q) begin
            we     = 1'b1;
            wdata  = wdat_q;
            wdirty = 1'b1;
          end else begin
            DataOut = line_q[l_idx];
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state, latched request and line array; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= 16'h0000;
      wdat_q  <= 16'h0000;
      opwr_q  <= 1'b0;
      valid_q <= '0;
      dirty_q <= '0;
      tag_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      opwr_q  <= opwr_d;
      if (we) begin
        valid_q[widx] <= 1'b1;
        dirty_q[widx] <= wdirty;
        tag_q[widx]   <= wtag;
        line_q[widx]  <= wdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_cache_ctrl.sv
// Scoreboard bench: stimulus pushes expected completions and memory requests,
// a monitor pops and compares whenever the DUT presents Done/err or a new memory op.
module tb_mem_cache_ctrl;
  logic        clk, rst;
  logic [15:0] Addr, DataIn, DataOut, mem_addr, mem_wdata, mem_rdata;
  logic        Rd, Wr, Done, Stall, CacheHit, err, mem_rd, mem_wr, mem_ready;

  mem_cache_ctrl #(.IDX_W(3)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct { bit is_err; bit hit; bit chk; logic [15:0] data; } resp_t;
  typedef struct { bit wr; logic [15:0] addr; logic [15:0] wdata; } mreq_t;

  resp_t       rq[$];
  mreq_t       mq[$];
  logic [15:0] mem_img[logic [15:0]];
  int          tests = 0;
  int          fails = 0;
  bit          resp_en = 1;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic exp_resp(bit is_err, bit hit, bit chk, logic [15:0] data);
    resp_t r;
    r.is_err = is_err; r.hit = hit; r.chk = chk; r.data = data;
    rq.push_back(r);
  endtask

  task automatic exp_mem(bit wr, logic [15:0] a, logic [15:0] wd);
    mreq_t m;
    m.wr = wr; m.addr = a; m.wdata = wd;
    mq.push_back(m);
  endtask

  // issue one request, check Stall on its first cycle, hold until Done/err (bounded)
  task automatic access(bit rd, bit wr, logic [15:0] a, logic [15:0] d, bit miss, string nm);
    bit seen;
    seen = 0;
    @(posedge clk); #1;
    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    @(negedge clk);
    check({nm, "_stall"}, {31'b0, Stall}, {31'b0, miss});
    for (int i = 0; i < 60; i++) begin
      if (Done || err) begin seen = 1; break; end
      @(negedge clk);
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no Done/err required one within 60 cycles", nm);
    end
    @(posedge clk); #1;
    Rd = 0; Wr = 0;
  endtask

  // backing memory: answers each request two cycles later with a one-cycle mem_ready
  initial begin
    mem_ready = 0; mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (resp_en && rst && (mem_rd || mem_wr)) begin
        repeat (2) @(posedge clk);
        #1;
        if (mem_wr) mem_img[mem_addr] = mem_wdata;
        else mem_rdata = mem_img.exists(mem_addr) ? mem_img[mem_addr] : 16'h0000;
        mem_ready = 1;
        @(posedge clk); #1;
        mem_ready = 0; mem_rdata = 16'h0000;
      end
    end
  end

  // monitor: compares completions and new memory ops against the queues
  initial begin
    logic [1:0] prev, cur;
    resp_t e;
    mreq_t m;
    prev = 2'b00;
    forever begin
      @(negedge clk);
      if (mem_rd && mem_wr) begin
        tests++; fails++;
        $display("FAIL mem_rd_wr_both: got rd=1 wr=1 required at most one");
      end
      if (Done || err) begin
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: got Done=%b err=%b required no response", Done, err);
        end else begin
          e = rq.pop_front();
          if (e.is_err) begin
            check("err_flag", {31'b0, err}, 32'd1);
            check("err_done", {31'b0, Done}, 32'd0);
            check("err_stall", {31'b0, Stall}, 32'd0);
          end else begin
            check("done_err", {31'b0, err}, 32'd0);
            check("cache_hit", {31'b0, CacheHit}, {31'b0, e.hit});
            if (e.chk) check("data_out", {16'b0, DataOut}, {16'b0, e.data});
          end
        end
      end
      cur = {mem_rd, mem_wr};
      if (cur != 2'b00 && cur != prev) begin
        if (mq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_mem: got rd=%b wr=%b addr=%h required none", mem_rd, mem_wr, mem_addr);
        end else begin
          m = mq.pop_front();
          check("mem_op_wr", {31'b0, mem_wr}, {31'b0, m.wr});
          check("mem_addr", {16'b0, mem_addr}, {16'b0, m.addr});
          if (m.wr) check("mem_wdata", {16'b0, mem_wdata}, {16'b0, m.wdata});
        end
      end
      prev = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_img[16'h0010] = 16'hBEEF;
    mem_img[16'h0020] = 16'h5555;
    mem_img[16'h0044] = 16'h0F0F;
    mem_img[16'h0054] = 16'h7777;
    mem_img[16'h0060] = 16'h6060;
    // reset held with a request present: every output must stay low
    rst = 0; Rd = 1; Wr = 0; Addr = 16'h0010; DataIn = 16'h0000;
    #12;
    check("rst_done", {31'b0, Done}, 32'd0);
    check("rst_stall", {31'b0, Stall}, 32'd0);
    check("rst_hit", {31'b0, CacheHit}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_mem_rdwr", {30'b0, mem_rd, mem_wr}, 32'd0);
    check("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
    check("rst_wdata", {16'b0, mem_wdata}, 32'd0);
    check("rst_dataout", {16'b0, DataOut}, 32'd0);
    Rd = 0;
    #1 rst = 1;

    // load miss, then load hit, then store hit
    exp_mem(0, 16'h0010, 16'h0); exp_resp(0, 0, 1, 16'hBEEF);
    access(1, 0, 16'h0010, 16'h0, 1, "rd10_miss");
    exp_resp(0, 1, 1, 16'hBEEF);
    access(1, 0, 16'h0010, 16'h0, 0, "rd10_hit");
    exp_resp(0, 1, 0, 16'h0);
    access(0, 1, 16'h0010, 16'h1234, 0, "wr10_hit");

    // conflict miss on a dirty line: write-back then fill
    exp_mem(1, 16'h0010, 16'h1234); exp_mem(0, 16'h0020, 16'h0); exp_resp(0, 0, 1, 16'h5555);
    access(1, 0, 16'h0020, 16'h0, 1, "rd20_wb");
    check("wb_mem_img", {16'b0, mem_img[16'h0010]}, {16'b0, 16'h1234});

    // illegal requests
    exp_resp(1, 0, 0, 16'h0);
    access(1, 1, 16'h0040, 16'h0, 0, "rdwr_err");
    exp_resp(1, 0, 0, 16'h0);
    access(1, 0, 16'h0011, 16'h0, 0, "odd_err");

    // store miss on a clean line, then read it back, then evict it
    exp_mem(0, 16'h0044, 16'h0); exp_resp(0, 0, 0, 16'h0);
    access(0, 1, 16'h0044, 16'hA5A5, 1, "wr44_miss");
    exp_resp(0, 1, 1, 16'hA5A5);
    access(1, 0, 16'h0044, 16'h0, 0, "rd44_hit");
    exp_mem(1, 16'h0044, 16'hA5A5); exp_mem(0, 16'h0054, 16'h0); exp_resp(0, 0, 1, 16'h7777);
    access(1, 0, 16'h0054, 16'h0, 1, "rd54_wb");
    check("wb44_mem_img", {16'b0, mem_img[16'h0044]}, {16'b0, 16'hA5A5});

    // reset in the middle of a fill
    resp_en = 0;
    exp_mem(0, 16'h0060, 16'h0);
    @(posedge clk); #1;
    Rd = 1; Addr = 16'h0060;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_rd) break;
    end
    check("fill_mem_rd_up", {31'b0, mem_rd}, 32'd1);
    #2 rst = 0;
    #1;
    check("arst_mem_rd", {31'b0, mem_rd}, 32'd0);
    check("arst_stall", {31'b0, Stall}, 32'd0);
    check("arst_done", {31'b0, Done}, 32'd0);
    Rd = 0;
    @(posedge clk); #1;
    rst = 1; resp_en = 1;
    exp_mem(0, 16'h0060, 16'h0); exp_resp(0, 0, 1, 16'h6060);
    access(1, 0, 16'h0060, 16'h0, 1, "rd60_again");

    repeat (3) @(negedge clk);
    check("resp_q_empty", rq.size(), 32'd0);
    check("mem_q_empty", mq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_cache_ctrl.md
MEM_CACHE_CTRL -- requirements
Module: mem_cache_ctrl

Interface
REQ-001 SHALL have parameter IDX_W, default 3: index width; the cache holds 2**IDX_W single-word lines.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 SHALL have port Addr  input  16  processor byte address; bit 0 must be 0.
REQ-005 SHALL have port DataIn  input  16  processor store data.
REQ-006 SHALL have port Rd  input  1  processor load request.
REQ-007 SHALL have port Wr  input  1  processor store request.
REQ-008 SHALL have port DataOut  output  16  load data, valid only while Done=1 for a load.
REQ-009 SHALL have port Done  output  1  one-cycle pulse marking access completion.
REQ-010 SHALL have port Stall  output  1  controller busy; processor holds Addr/DataIn/Rd/Wr stable while high.
REQ-011 SHALL have port CacheHit  output  1  asserted with Done when the access hit without memory traffic.
REQ-012 SHALL have port err  output  1  illegal request flag.
REQ-013 SHALL have ports mem_addr (output, 16), mem_wdata (output, 16), mem_rd (output, 1), mem_wr (output, 1): backing-memory request.
REQ-014 SHALL have ports mem_rdata (input, 16) and mem_ready (input, 1): backing-memory response, mem_ready a one-cycle completion pulse.

Function
REQ-015 Line fields SHALL be: index = Addr[IDX_W:1], tag = Addr[15:IDX_W+1]; each line stores valid, dirty, tag, 16-bit data.
REQ-016 FSM states SHALL be IDLE, WB, FILL, FINISH.
REQ-017 In IDLE, a legal request (exactly one of Rd/Wr, Addr[0]=0) SHALL be looked up combinationally in the same cycle.
REQ-018 Hit (valid and tag match) SHALL assert Done=1, CacheHit=1, Stall=0 that cycle; load: DataOut = line data; store: line data <= DataIn, dirty <= 1 at the edge; state stays IDLE.
REQ-019 Miss SHALL assert Stall=1, Done=0, latch Addr/DataIn/op, go to WB if the victim is valid and dirty, else to FILL.
REQ-020 WB SHALL hold mem_wr=1, mem_addr = {victim tag, index, 1'b0}, mem_wdata = victim data until mem_ready, then go to FILL.
REQ-021 FILL SHALL hold mem_rd=1, mem_addr = latched address until mem_ready; on mem_ready install valid=1, dirty=0, new tag, data=mem_rdata; go to FINISH.
REQ-022 FINISH SHALL last one cycle: Done=1, CacheHit=0, Stall=0; load: DataOut = installed data; store: merge DataIn, dirty <= 1; return to IDLE.
REQ-023 Stall SHALL be 1 in WB and FILL and on the IDLE miss cycle; requests seen outside IDLE SHALL be ignored.
REQ-024 mem_rd and mem_wr SHALL never be high together; both 0 in IDLE and FINISH.
REQ-025 Rd=Wr=1, or Rd|Wr with Addr[0]=1, SHALL in IDLE assert err=1 for that cycle, Done=0, Stall=0, no state or memory change.
REQ-026 Rd=Wr=0 in IDLE SHALL produce Done=0, Stall=0, CacheHit=0, err=0.
REQ-027 mem_ready outside WB/FILL SHALL be ignored.

Reset
REQ-028 rst=0 SHALL immediately (asynchronously) force state IDLE, clear every valid and dirty bit, and drive Done, Stall, CacheHit, err, mem_rd, mem_wr to 0, mem_addr, mem_wdata to 0x0000 and DataOut to 0x0000.
REQ-029 Reset during WB or FILL SHALL abandon the transfer with no line installed and no Done pulse.

Verification
REQ-030 After reset, Rd Addr=0x0010 -> Stall=1, mem_rd=1 mem_addr=0x0010; mem_ready with mem_rdata=0xBEEF -> next cycle Done=1 CacheHit=0 DataOut=0xBEEF; repeat Rd -> same-cycle Done=1 CacheHit=1 DataOut=0xBEEF.
REQ-031 Then Wr 0x0010 DataIn=0x1234 -> same-cycle Done=1 CacheHit=1, mem_wr never asserted.
REQ-032 Then Rd 0x0020 (same index, new tag) -> mem_wr=1 addr 0x0010 wdata 0x1234 until mem_ready, then mem_rd addr 0x0020; mem_rdata 0x5555 -> Done=1 DataOut=0x5555 CacheHit=0.
REQ-033 Rd=Wr=1 at 0x0040, and Rd at 0x0011 -> err=1 one cycle each, Done=0, no mem_rd/mem_wr.
REQ-034 Wr miss 0x0044 DataIn=0xA5A5 on clean line -> FILL then FINISH Done=1; later conflicting Rd 0x0054 triggers write-back of 0xA5A5 to 0x0044.
REQ-035 rst=0 while mem_rd=1 -> mem_rd and Stall drop without a clock edge; after release, Rd of same address misses again.
